// File: rtl/beam_trigger_scaler_lowampa.sv
// Edge-detects and masks beamformer trigger bits, gates per-bit saturating scalers and merges edges
// into one held-off trigger pulse. Define BEAM_SCALER_DEADTIME_EN to build the HOLD dead-time counter.
module beam_trigger_scaler_lowampa #(
  parameter int NBEAMS       = 2,
  parameter int CNT_BITS     = 16,
  parameter int PERIOD_BITS  = 24,
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [2*NBEAMS-1:0]             trigger_i,
  input  logic [2*NBEAMS-1:0]             mask_i,
  input  logic [PERIOD_BITS-1:0]          period_i,
  input  logic [HOLDOFF_BITS-1:0]         holdoff_i,
  output logic                            trig_o,
  output logic [2*NBEAMS-1:0]             trig_beams_o,
  output logic [2*NBEAMS*CNT_BITS-1:0]    scaler_o,
  output logic                            scaler_valid_o,
  output logic [PERIOD_BITS-1:0]          deadtime_o
);
  localparam int NTRIG = 2 * NBEAMS;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  function automatic logic [CNT_BITS-1:0] sat_inc_cnt(input logic [CNT_BITS-1:0] v, input logic inc);
    logic [CNT_BITS-1:0] r;
    if (inc && (v != {CNT_BITS{1'b1}})) r = v + CNT_BITS'(1);
    else                                r = v;
    return r;
  endfunction

  logic [NTRIG-1:0]          trigger_q;
  logic [NTRIG-1:0]          ev_s;
  logic [CNT_BITS-1:0]       cnt_q   [NTRIG];
  logic [CNT_BITS-1:0]       cnt_d   [NTRIG];
  logic [CNT_BITS-1:0]       cnt_inc_s [NTRIG];
  logic [NTRIG*CNT_BITS-1:0] scaler_q, scaler_d;
  logic                      scaler_valid_q;
  logic [PERIOD_BITS-1:0]    gcnt_q, gcnt_d;
  logic                      gate_end_s;
  state_t                    state_q;
  logic [HOLDOFF_BITS-1:0]   hcnt_q;
  logic                      trig_q;
  logic [NTRIG-1:0]          trig_beams_q;

  assign ev_s       = trigger_i & ~trigger_q & ~mask_i;
  assign gate_end_s = (gcnt_q >= period_i);

  // Scaler next state: the gate-end cycle's own edges land in the published count.
  always_comb begin
    scaler_d = scaler_q;
    if (gate_end_s) gcnt_d = '0;
    else            gcnt_d = gcnt_q + PERIOD_BITS'(1);
    for (int k = 0; k < NTRIG; k++) begin
      cnt_inc_s[k] = sat_inc_cnt(cnt_q[k], ev_s[k]);
      if (gate_end_s) begin
        scaler_d[k*CNT_BITS +: CNT_BITS] = cnt_inc_s[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_inc_s[k];
      end
    end
  end

  // Edge-detect history, running counts, gate counter and published scalers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trigger_q      <= '0;
      gcnt_q         <= '0;
      scaler_q       <= '0;
      scaler_valid_q <= 1'b0;
      for (int k = 0; k < NTRIG; k++) cnt_q[k] <= '0;
    end else begin
      trigger_q      <= trigger_i;
      gcnt_q         <= gcnt_d;
      scaler_q       <= scaler_d;
      scaler_valid_q <= gate_end_s;
      for (int k = 0; k < NTRIG; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // Trigger FSM; holdoff_i is captured only when a HOLD starts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hcnt_q       <= '0;
      trig_q       <= 1'b0;
      trig_beams_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|ev_s) begin
            trig_q       <= 1'b1;
            trig_beams_q <= ev_s;
            state_q      <= HOLD;
            hcnt_q       <= holdoff_i;
          end else begin
            trig_q <= 1'b0;
          end
        end
        HOLD: begin
          trig_q <= 1'b0;
          if (hcnt_q == '0) state_q <= IDLE;
          else              hcnt_q  <= hcnt_q - HOLDOFF_BITS'(1);
        end
        default: begin
          trig_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign trig_o         = trig_q;
  assign trig_beams_o   = trig_beams_q;
  assign scaler_o       = scaler_q;
  assign scaler_valid_o = scaler_valid_q;

`ifdef BEAM_SCALER_DEADTIME_EN
  function automatic logic [PERIOD_BITS-1:0] sat_inc_per(input logic [PERIOD_BITS-1:0] v, input logic inc);
    logic [PERIOD_BITS-1:0] r;
    if (inc && (v != {PERIOD_BITS{1'b1}})) r = v + PERIOD_BITS'(1);
    else                                   r = v;
    return r;
  endfunction

  logic [PERIOD_BITS-1:0] dcnt_q;
  logic [PERIOD_BITS-1:0] deadtime_q;

  // Dead-time accumulation; a HOLD cycle coinciding with gate end is included in the latched value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dcnt_q     <= '0;
      deadtime_q <= '0;
    end else if (gate_end_s) begin
      deadtime_q <= sat_inc_per(dcnt_q, state_q == HOLD);
      dcnt_q     <= '0;
    end else begin
      dcnt_q     <= sat_inc_per(dcnt_q, state_q == HOLD);
    end
  end

  assign deadtime_o = deadtime_q;
`else
  assign deadtime_o = '0;
`endif

endmodule
